// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The master issues a request and holds it until the slave answers with ready.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores on a variable-latency bus, stalls the
// front of the pipeline while an access is outstanding, resolves branches and
// jumps, and holds the MEM/WB register for write-back.
module mem_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_number_in,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemtoReg_in,
    input  logic        is_jal_in,
    input  logic        zero_in,
    input  logic [1:0]  Branch_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] PC_add_imm_in,
    input  logic [31:0] Read_data_2_in,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        PC_src,
    output logic [31:0] branch_target,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] Read_data_out,
    output logic [31:0] ALU_result_out,
    output logic        mem_fault,
    output logic [31:0] fault_addr
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q;
    logic [CW-1:0] waitCount_q;
    logic        heldWe_q;
    logic [31:0] heldAddr_q;
    logic [31:0] heldWdata_q;

    logic        regWrite_q;
    logic        memtoReg_q;
    logic [4:0]  rd_q;
    logic [31:0] readData_q;
    logic [31:0] aluResult_q;
    logic        memFault_q;
    logic [31:0] faultAddr_q;

    logic        isAccess;
    logic        misaligned;
    logic        timeout;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic        fault;
    logic        loadDone;
    logic [31:0] readData_d;
    logic [31:0] aluResult_d;

    // Bus drive, stall, fault detection: fresh from EX/MEM in IDLE, replayed from the held copy in WAIT.
    always_comb begin
        isAccess    = MemRead_in | MemWrite_in;
        misaligned  = (state_q == IDLE) & isAccess & (ALU_result_in[1:0] != 2'b00);
        busReq      = 1'b0;
        busWe       = MemWrite_in;
        busAddr     = ALU_result_in;
        busWdata    = Read_data_2_in;
        if (state_q == IDLE) begin
            busReq = isAccess & ~misaligned;
        end else begin
            busReq   = 1'b1;
            busWe    = heldWe_q;
            busAddr  = heldAddr_q;
            busWdata = heldWdata_q;
        end
        busReq      = busReq & ~rst;
        timeout     = (state_q == WAIT) & ~dmem.dmem_ready &
                      (waitCount_q == CW'(MEM_TIMEOUT - 1));
        mem_stall   = busReq & ~dmem.dmem_ready & ~timeout;
        fault       = misaligned | timeout;
        loadDone    = busReq & dmem.dmem_ready & ~busWe;
        readData_d  = loadDone ? dmem.dmem_rdata : 32'h0;
        aluResult_d = is_jal_in ? (PC_number_in + 32'd4) : ALU_result_in;
    end

    // Access FSM with wait counter, plus the MEM/WB register and the fault record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            waitCount_q <= '0;
            heldWe_q    <= 1'b0;
            heldAddr_q  <= 32'h0;
            heldWdata_q <= 32'h0;
            regWrite_q  <= 1'b0;
            memtoReg_q  <= 1'b0;
            rd_q        <= 5'd0;
            readData_q  <= 32'h0;
            aluResult_q <= 32'h0;
            memFault_q  <= 1'b0;
            faultAddr_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (busReq & ~dmem.dmem_ready) begin
                        state_q     <= WAIT;
                        waitCount_q <= CW'(1);
                        heldWe_q    <= busWe;
                        heldAddr_q  <= busAddr;
                        heldWdata_q <= busWdata;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ready | timeout) begin
                        state_q     <= IDLE;
                        waitCount_q <= '0;
                    end else begin
                        waitCount_q <= waitCount_q + CW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    waitCount_q <= '0;
                end
            endcase

            if (mem_stall) begin
                regWrite_q <= 1'b0;
                memtoReg_q <= 1'b0;
                rd_q       <= 5'd0;
            end else begin
                regWrite_q  <= RegWrite_in & ~fault;
                memtoReg_q  <= MemtoReg_in;
                rd_q        <= Rd_in;
                readData_q  <= readData_d;
                aluResult_q <= aluResult_d;
            end

            memFault_q <= fault;
            if (fault) begin
                faultAddr_q <= busAddr;
            end
        end
    end

    assign dmem.dmem_req   = busReq;
    assign dmem.dmem_we    = busWe;
    assign dmem.dmem_addr  = busAddr;
    assign dmem.dmem_wdata = busWdata;

    assign PC_src = is_jal_in | ((Branch_in == 2'b01) & zero_in) |
                    ((Branch_in == 2'b10) & ~zero_in) | (Branch_in == 2'b11);
    assign branch_target = PC_add_imm_in;

    assign RegWrite_out   = regWrite_q;
    assign MemtoReg_out   = memtoReg_q;
    assign Rd_out         = rd_q;
    assign Read_data_out  = readData_q;
    assign ALU_result_out = aluResult_q;
    assign mem_fault      = memFault_q;
    assign fault_addr     = faultAddr_q;

endmodule
